// File: rtl/dma_sample_unpacker_pkg.sv
// Shared definitions for the DMA sample unpacker: request FSM encoding and DMA word width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dma_sample_unpacker_pkg;

    localparam int DMA_WORD_W = 64;

    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_WAIT = 2'd1,
        REQ_GAP  = 2'd2
    } req_state_t;

endpackage

// File: rtl/dma_word_buf2.sv
// Two-entry DMA word buffer (head/tail) with push, pop and occupancy count.
// Latency: a pushed word becomes visible on head the cycle after push.
// Backpressure: none; the caller never pushes when full (pops issued when empty are ignored).
module dma_word_buf2
    import dma_sample_unpacker_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DMA_WORD_W-1:0] push_dat,
    input  logic                  pop,
    output logic [DMA_WORD_W-1:0] head_dat,
    output logic                  head_vld,
    output logic [1:0]            count
);

    logic [DMA_WORD_W-1:0] ent_head;
    logic [DMA_WORD_W-1:0] ent_tail;
    logic [1:0]            cnt;
    logic                  do_pop;

    assign do_pop   = pop && (cnt != 2'd0);
    assign head_dat = ent_head;
    assign head_vld = (cnt != 2'd0);
    assign count    = cnt;

    // Occupancy and entry update; a simultaneous push and pop keeps occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 2'd0;
            ent_head <= '0;
            ent_tail <= '0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push) begin
                        ent_head <= push_dat;
                        cnt      <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && do_pop) begin
                        ent_head <= push_dat;
                    end else if (push) begin
                        ent_tail <= push_dat;
                        cnt      <= 2'd2;
                    end else if (do_pop) begin
                        cnt <= 2'd0;
                    end
                end
                default: begin
                    if (do_pop) begin
                        ent_head <= ent_tail;
                        if (push) begin
                            ent_tail <= push_dat;
                        end else begin
                            cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/dma_sample_unpacker.sv
// Pulls 64-bit DMA words on demand and unpacks them into SAMPLE_W samples, one per sample_tick (optional counter: UNPACK_UNDERFLOW_CNT_EN).
// Latency: sample_valid/sample_data/underflow registered exactly 1 cycle after sample_tick.
// Backpressure: none; upstream is paced by pull requests, an empty buffer on a tick substitutes a silence sample.
module dma_sample_unpacker
    import dma_sample_unpacker_pkg::*;
#(
    parameter int SAMPLE_W      = 16,
    parameter int MAX_RETRY_GAP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  dmac_request,
    input  logic                  dmac_valid,
    input  logic [DMA_WORD_W-1:0] dmac_data,
    input  logic                  sample_tick,
    output logic                  sample_valid,
    output logic [SAMPLE_W-1:0]   sample_data,
    output logic                  underflow
`ifdef UNPACK_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]           underflow_count
`endif
);

    localparam int LANES  = DMA_WORD_W / SAMPLE_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int GAP_W  = $clog2(MAX_RETRY_GAP + 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(MAX_RETRY_GAP - 1);

    req_state_t                        state;
    logic [GAP_W-1:0]                  gap_cnt;
    logic [LANE_W-1:0]                 lane_idx;
    logic [DMA_WORD_W-1:0]             head_dat;
    logic [LANES-1:0][SAMPLE_W-1:0]    head_lanes;
    logic                              head_vld;
    logic [1:0]                        buf_count;
    logic                              capture;
    logic                              tick_pop;

    // In IDLE nothing is outstanding, so occupancy alone bounds words held + outstanding.
    // The request is a Mealy output so the response lands exactly in the single WAIT cycle.
    assign dmac_request = !rst && (state == REQ_IDLE) && enable && (buf_count < 2'd2);
    assign capture      = (state == REQ_WAIT) && dmac_valid;
    assign tick_pop     = sample_tick && head_vld && (lane_idx == LAST_LANE);
    assign head_lanes   = head_dat;

    dma_word_buf2 u_word_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (capture),
        .push_dat (dmac_data),
        .pop      (tick_pop),
        .head_dat (head_dat),
        .head_vld (head_vld),
        .count    (buf_count)
    );

    // Request FSM: one outstanding pull, a missed response waits out the retry gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= REQ_IDLE;
            gap_cnt <= '0;
        end else begin
            case (state)
                REQ_IDLE: begin
                    if (dmac_request) begin
                        state <= REQ_WAIT;
                    end
                end
                REQ_WAIT: begin
                    if (dmac_valid) begin
                        state <= REQ_IDLE;
                    end else begin
                        state   <= REQ_GAP;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                REQ_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= REQ_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= REQ_IDLE;
            endcase
        end
    end

    // Sample output: next lane of the head word, or silence with underflow when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_valid <= 1'b0;
            sample_data  <= '0;
            underflow    <= 1'b0;
            lane_idx     <= '0;
        end else begin
            sample_valid <= sample_tick;
            underflow    <= 1'b0;
            if (sample_tick) begin
                if (head_vld) begin
                    sample_data <= head_lanes[lane_idx];
                    lane_idx    <= (lane_idx == LAST_LANE) ? '0 : lane_idx + 1'b1;
                end else begin
                    sample_data <= '0;
                    underflow   <= 1'b1;
                end
            end
        end
    end

`ifdef UNPACK_UNDERFLOW_CNT_EN
    // Saturating count of substituted silence samples, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_count <= 16'd0;
        end else if (sample_tick && !head_vld && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_sample_unpacker.sv
// Scoreboard bench for dma_sample_unpacker: random and directed stimulus against a sample-queue reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dma_sample_unpacker;

    localparam int SW    = 16;
    localparam int LANES = 64 / SW;
    localparam int GAP   = 1;

    typedef struct {
        logic [31:0] dat;
        logic        uf;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        rst, enable, dmac_request, dmac_valid, sample_tick, sample_valid, underflow;
    logic [63:0] dmac_data;
    logic [15:0] sample_data;
    // 32-bit instance
    logic        rst32, enable32, req32, valid32, tick32, sv32, uf32;
    logic [63:0] data32;
    logic [31:0] sd32;
`ifdef UNPACK_UNDERFLOW_CNT_EN
    logic [15:0] underflow_count, ucnt32;
`endif

    dma_sample_unpacker #(.SAMPLE_W(SW), .MAX_RETRY_GAP(GAP)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .dmac_request(dmac_request),
        .dmac_valid(dmac_valid), .dmac_data(dmac_data), .sample_tick(sample_tick),
        .sample_valid(sample_valid), .sample_data(sample_data), .underflow(underflow)
`ifdef UNPACK_UNDERFLOW_CNT_EN
        , .underflow_count(underflow_count)
`endif
    );

    dma_sample_unpacker #(.SAMPLE_W(32), .MAX_RETRY_GAP(GAP)) u_dut32 (
        .clk(clk), .rst(rst32), .enable(enable32), .dmac_request(req32),
        .dmac_valid(valid32), .dmac_data(data32), .sample_tick(tick32),
        .sample_valid(sv32), .sample_data(sd32), .underflow(uf32)
`ifdef UNPACK_UNDERFLOW_CNT_EN
        , .underflow_count(ucnt32)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t        sb[$];
    exp_t        sb32[$];
    logic [15:0] mq[$];       // samples the consumer is still owed, in order
    logic [63:0] word_q[$];   // directed words for the upstream responder
    int          last_req = -100;
    bit          missed   = 1'b0;
    bit          resp_pend = 1'b0;
    logic [63:0] resp_word = '0;
    bit          stale    = 1'b0;
    int          ans_mode = 0;  // 0 never answer, 1 always, 2 answer 3 out of 4
    bit          drv_en   = 1'b0;
    bit          drv_tick = 1'b0;
    int          uf_model = 0;
    bit          done32   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reset for n cycles; reset values are checked once the reset edge has been taken.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cyc++;
            rst = 1'b1; enable = 1'b0; sample_tick = 1'b0; dmac_valid = 1'b0;
            @(negedge clk);
            if (i >= 1) begin
                chk("rst_dmac_request", dmac_request, 0);
                chk("rst_sample_valid", sample_valid, 0);
                chk("rst_sample_data", sample_data, 0);
                chk("rst_underflow", underflow, 0);
`ifdef UNPACK_UNDERFLOW_CNT_EN
                chk("rst_underflow_count", underflow_count, 0);
`endif
            end
        end
        mq.delete();
        word_q.delete();
        last_req  = -100;
        missed    = 1'b0;
        resp_pend = 1'b0;
        stale     = 1'b0;
        uf_model  = 0;
    endtask

    // One cycle: drive inputs after the edge, then advance the reference model mid-cycle.
    task automatic step();
        bit          cur_resp;
        logic [63:0] cur_word;
        int          held;
        bit          blocked, exp_req, ans;
        @(posedge clk); #1;
        cyc++;
        rst         = 1'b0;
        enable      = drv_en;
        sample_tick = drv_tick;
        cur_resp    = resp_pend;
        cur_word    = resp_word;
        dmac_valid  = resp_pend | stale;
        dmac_data   = resp_pend ? resp_word : {$urandom, $urandom};
        resp_pend   = 1'b0;
        stale       = 1'b0;
        @(negedge clk);
        held    = (mq.size() + LANES - 1) / LANES;
        blocked = (cyc == last_req + 1) || (missed && cyc <= last_req + 1 + GAP);
        exp_req = drv_en && !blocked && (held < 2);
        chk("dmac_request", dmac_request, exp_req);
        if (exp_req) begin
            last_req = cyc;
            ans = (ans_mode == 1) || (ans_mode == 2 && ($urandom % 4) != 0);
            missed = !ans;
            if (ans) begin
                resp_pend = 1'b1;
                resp_word = (word_q.size() > 0) ? word_q.pop_front() : {$urandom, $urandom};
            end
        end
        if (drv_tick) begin
            if (mq.size() > 0) begin
                sb.push_back('{dat: {16'd0, mq.pop_front()}, uf: 1'b0, due: cyc + 1});
            end else begin
                sb.push_back('{dat: 32'd0, uf: 1'b1, due: cyc + 1});
                if (uf_model < 65535) uf_model++;
            end
        end
        if (cur_resp) begin
            for (int i = 0; i < LANES; i++) mq.push_back(cur_word[i*SW +: SW]);
        end
    endtask

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (sample_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sample_unexpected: got sample %0h with nothing expected (cycle %0d)", sample_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("sample_cycle", cyc, e.due);
                chk("sample_data", sample_data, e.dat);
                chk("sample_underflow", underflow, e.uf);
            end
        end else begin
            chk("underflow_idle", underflow, 0);
        end
    end

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (sv32) begin
            if (sb32.size() == 0) begin
                checks++; errors++;
                $display("FAIL sample32_unexpected: got sample %0h with nothing expected", sd32);
            end else begin
                e = sb32.pop_front();
                chk("sample32_data", sd32, e.dat);
                chk("sample32_underflow", uf32, e.uf);
            end
        end
    end

    // 32-bit lane check: one word, three ticks.
    initial begin
        logic [63:0] w;
        int k;
        w = 64'hBBBB_BBBB_AAAA_AAAA;
        rst32 = 1'b1; enable32 = 1'b0; valid32 = 1'b0; data32 = '0; tick32 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst32 = 1'b0; enable32 = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req32) break;
        end
        chk("dut32_request", req32, 1);
        @(posedge clk); #1 enable32 = 1'b0; valid32 = 1'b1; data32 = w;
        @(posedge clk); #1 valid32 = 1'b0; tick32 = 1'b1;
        sb32.push_back('{dat: w[31:0], uf: 1'b0, due: 0});
        @(posedge clk); #1
        sb32.push_back('{dat: w[63:32], uf: 1'b0, due: 0});
        @(posedge clk); #1
        sb32.push_back('{dat: 32'd0, uf: 1'b1, due: 0});
        @(posedge clk); #1 tick32 = 1'b0;
        repeat (3) @(posedge clk);
        done32 = 1'b1;
    end

    initial begin
        int rate;
        rst = 1'b1; enable = 1'b0; dmac_valid = 1'b0; dmac_data = '0; sample_tick = 1'b0;
        do_reset(2);

        // Two known words answered on every request, eight ticks back to back.
        ans_mode = 1; drv_en = 1'b1;
        word_q.push_back(64'h0004_0003_0002_0001);
        word_q.push_back(64'h0008_0007_0006_0005);
        drv_tick = 1'b0; repeat (6) step();
        drv_tick = 1'b1; repeat (8) step();
        drv_tick = 1'b0; repeat (4) step();

        // Upstream silent: retry cadence and silence substitution.
        do_reset(2);
        ans_mode = 0; drv_en = 1'b1;
        repeat (30) begin drv_tick = ($urandom % 2) == 1; step(); end
        drv_tick = 1'b0; step();

        // Tick coincident with the first response into an empty buffer.
        do_reset(2);
        ans_mode = 1; drv_en = 1'b1; word_q.push_back(64'h1);
        for (int k = 0; k < 10 && !resp_pend; k++) step();
        chk("coincident_req_seen", resp_pend, 1);
        drv_en = 1'b0; drv_tick = 1'b1; step();
        drv_tick = 1'b0; step();
        drv_tick = 1'b1; step();
        drv_tick = 1'b0; repeat (2) step();

        // Randomized traffic with varying tick density.
        do_reset(2);
        ans_mode = 2;
        for (int blk = 0; blk < 10; blk++) begin
            rate = $urandom_range(10, 90);
            repeat (200) begin
                drv_en   = ($urandom % 8) != 0;
                drv_tick = ($urandom % 100) < rate;
                step();
            end
        end
        drv_tick = 1'b0; repeat (3) step();
`ifdef UNPACK_UNDERFLOW_CNT_EN
        chk("underflow_count_random", underflow_count, uf_model);
`endif

        // Reset during WAIT; the late response after release must be ignored.
        do_reset(2);
        ans_mode = 0; drv_en = 1'b1; drv_tick = 1'b0;
        for (int k = 0; k < 10 && last_req != cyc; k++) step();
        chk("wait_reset_req_seen", last_req == cyc, 1);
        do_reset(1);
        drv_en = 1'b0; stale = 1'b1; step();
        drv_tick = 1'b1; step();
        drv_tick = 1'b0; step();
        drv_tick = 1'b1; step();
        drv_tick = 1'b0; repeat (2) step();

`ifdef UNPACK_UNDERFLOW_CNT_EN
        // Saturation of the underflow counter, then reset clears it.
        do_reset(2);
        drv_en = 1'b0; drv_tick = 1'b1;
        repeat (65540) step();
        drv_tick = 1'b0; step();
        chk("underflow_count_model", underflow_count, uf_model);
        chk("underflow_count_sat", underflow_count, 16'hFFFF);
        do_reset(2);
`endif

        for (int k = 0; k < 200 && !done32; k++) @(posedge clk);
        chk("dut32_done", done32, 1);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("sb32_drained", sb32.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
